// File: rtl/fifo_cam_sync.sv
// Single-clock FIFO for camera pixel words (pixel + frame-start marker).
// Standard read mode: Q updates on the edge after an accepted read.
module fifo_cam_sync #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  WrEn,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Empty,
    output logic                  Full,
    output logic [ADDR_WIDTH:0]   Wnum
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the flags as they stand before the edge, so a write
    // into a full FIFO is dropped even when a read frees a slot that cycle.
    assign wr_ok = WrEn && !Full;
    assign rd_ok = RdEn && !Empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            Q    <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                Q    <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage is not reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= Data;
        end
    end

    // The extra wrap bit distinguishes full from empty when addresses match.
    assign Empty = (wptr == rptr);
    assign Full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign Wnum  = wptr - rptr;

endmodule

// File: tb/tb_fifo_cam_sync.sv
// Randomized scoreboard bench for fifo_cam_sync against a queue-based model.
module tb_fifo_cam_sync;

    localparam int DW    = 17;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] Data;
    logic          WrEn;
    logic          RdEn;
    logic [DW-1:0] Q;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Wnum;

    typedef struct {
        logic [DW-1:0] q;
        logic [AW:0]   wnum;
        logic          empty;
        logic          full;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model[$];
    logic [DW-1:0] last_q;
    int            checks;
    int            errors;
    exp_t          mon_e;

    fifo_cam_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Data  (Data),
        .WrEn  (WrEn),
        .RdEn  (RdEn),
        .Q     (Q),
        .Empty (Empty),
        .Full  (Full),
        .Wnum  (Wnum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge and queue the state expected after the next rising edge.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        bit   wr_acc;
        bit   rd_acc;
        @(negedge clk);
        WrEn   = wr;
        RdEn   = rd;
        Data   = d;
        wr_acc = wr && (model.size() < DEPTH);
        rd_acc = rd && (model.size() > 0);
        if (rd_acc) last_q = model.pop_front();
        if (wr_acc) model.push_back(d);
        e.q     = last_q;
        e.wnum  = (AW+1)'(model.size());
        e.empty = (model.size() == 0);
        e.full  = (model.size() == DEPTH);
        sb.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_empty"}, 32'(Empty), 32'd1);
        checkOutput({tag, "_full"},  32'(Full),  32'd0);
        checkOutput({tag, "_wnum"},  32'(Wnum),  32'd0);
        checkOutput({tag, "_q"},     32'(Q),     32'd0);
    endtask

    // Monitor: compares DUT outputs just after every rising edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("q",     32'(Q),     32'(mon_e.q));
                checkOutput("wnum",  32'(Wnum),  32'(mon_e.wnum));
                checkOutput("empty", 32'(Empty), 32'(mon_e.empty));
                checkOutput("full",  32'(Full),  32'(mon_e.full));
            end
        end
    end

    initial begin
        int written;
        int cycles;
        checks = 0;
        errors = 0;
        last_q = '0;
        rst_n  = 1'b0;
        WrEn   = 1'b1;
        RdEn   = 1'b0;
        Data   = 17'h1FFFF;

        // Reset held with a pending write request.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkReset("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        WrEn  = 1'b0;

        applyStimulus(1'b1, 1'b0, 17'h1ABCD);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        // Fill to depth, attempt one dropped write, then drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
        applyStimulus(1'b1, 1'b0, 17'h0FFFF);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0);

        // Reads while empty must leave Q and occupancy alone.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 17'h0A5A5);
        applyStimulus(1'b0, 1'b1, '0);

        // Simultaneous read and write at occupancy one.
        applyStimulus(1'b1, 1'b0, 17'h00001);
        applyStimulus(1'b1, 1'b1, 17'h00002);
        applyStimulus(1'b0, 1'b1, '0);

        // Random interleaved streaming across many pointer wraps.
        written = 0;
        cycles  = 0;
        while (written < 3000 && cycles < 20000) begin
            bit wr;
            bit rd;
            wr = ($urandom_range(0, 99) < 60) && (model.size() < DEPTH - 4);
            rd = ($urandom_range(0, 99) < 50);
            if (wr) written++;
            applyStimulus(wr, rd, DW'($urandom));
            cycles++;
        end
        while (model.size() > 0) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        // Asynchronous reset between edges with 500 words stored.
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
        @(negedge clk);
        WrEn  = 1'b0;
        RdEn  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkReset("rst_async");
        model.delete();
        last_q = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 17'h10123);
        applyStimulus(1'b1, 1'b0, 17'h04567);
        applyStimulus(1'b1, 1'b1, 17'h189AB);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        @(negedge clk);
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
